// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: source-select encoding and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_select_stage_if.sv
// MEM->WB bundle: upstream entry, pipeline control and registered writeback outputs.
interface wb_select_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        wb_sel;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
    logic [2:0]        funct3;
    logic [1:0]        byte_off;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we_in;
    logic              wb_valid;
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_we;
    logic [CNT_W-1:0]  instret;

    modport master (
        output in_valid, stall, flush, wb_sel, alu_res, load_data, pc_plus4, imm,
               funct3, byte_off, rd_addr, rd_we_in,
        input  wb_valid, wb_data, wb_rd, wb_we, instret
    );

    modport slave (
        input  in_valid, stall, flush, wb_sel, alu_res, load_data, pc_plus4, imm,
               funct3, byte_off, rd_addr, rd_we_in,
        output wb_valid, wb_data, wb_rd, wb_we, instret
    );
endinterface

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension of a raw data-memory word.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] ext_data
);
    logic [7:0]  word_bytes [4];
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_w;

    // Lanes are always taken from the low 32 bits; wider offsets are resolved upstream.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = load_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_b = word_bytes[byte_off];
        lane_h = byte_off[1] ? {word_bytes[3], word_bytes[2]} : {word_bytes[1], word_bytes[0]};
        lane_w = load_data[31:0];
        ext_data = load_data;
        case (funct3)
            F3_LB:   ext_data = XLEN'($signed(lane_b));
            F3_LH:   ext_data = XLEN'($signed(lane_h));
            F3_LW:   ext_data = XLEN'($signed(lane_w));
            F3_LBU:  ext_data = XLEN'(lane_b);
            F3_LHU:  ext_data = XLEN'(lane_h);
            default: ext_data = load_data;
        endcase
    end
endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register with writeback-source select, x0 write suppression and retire counter.
// Optional load extension is built when WB_LOAD_EXT_EN is defined.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic clk,
    input  logic rst,
    wb_select_stage_if.slave bus
);
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   data_next;
    logic              we_next;

    logic              valid_reg;
    logic              we_reg;
    logic [XLEN-1:0]   data_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [CNT_W-1:0]  instret_reg;

`ifdef WB_LOAD_EXT_EN
    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3    (bus.funct3),
        .byte_off  (bus.byte_off),
        .load_data (bus.load_data),
        .ext_data  (mem_data)
    );
`else
    logic unused_ext;
    assign mem_data   = bus.load_data;
    assign unused_ext = ^{bus.funct3, bus.byte_off};
`endif

    always_comb begin
        sel_data = bus.alu_res;
        case (wb_sel_e'(bus.wb_sel))
            WB_ALU:  sel_data = bus.alu_res;
            WB_MEM:  sel_data = mem_data;
            WB_PC4:  sel_data = bus.pc_plus4;
            WB_IMM:  sel_data = bus.imm;
            default: sel_data = bus.alu_res;
        endcase
    end

    // Bubbles carry zero data; x0 is never written.
    assign data_next = bus.in_valid ? sel_data : '0;
    assign we_next   = bus.in_valid & bus.rd_we_in & (bus.rd_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            we_reg      <= 1'b0;
            data_reg    <= '0;
            rd_reg      <= '0;
            instret_reg <= '0;
        end else if (bus.flush) begin
            valid_reg <= 1'b0;
            we_reg    <= 1'b0;
            data_reg  <= '0;
            rd_reg    <= '0;
        end else if (!bus.stall) begin
            valid_reg   <= bus.in_valid;
            we_reg      <= we_next;
            data_reg    <= data_next;
            rd_reg      <= bus.rd_addr;
            instret_reg <= instret_reg + CNT_W'(bus.in_valid);
        end
    end

    assign bus.wb_valid = valid_reg;
    assign bus.wb_we    = we_reg;
    assign bus.wb_data  = data_reg;
    assign bus.wb_rd    = rd_reg;
    assign bus.instret  = instret_reg;
endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: default-width instance plus a 4-bit-counter instance for wrap.
module tb_wb_select_stage;
    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    wb_select_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) bus_a ();
    wb_select_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  bus_b ();

    wb_select_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    wb_select_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic we);
        bus_a.in_valid  = v;
        bus_a.wb_sel    = sel;
        bus_a.alu_res   = alu;
        bus_a.load_data = ld;
        bus_a.funct3    = f3;
        bus_a.byte_off  = off;
        bus_a.rd_addr   = rd;
        bus_a.rd_we_in  = we;
    endtask

    task automatic check_a(input string tag, input logic v, input logic we, input logic [31:0] d,
                           input logic [4:0] rd, input logic [63:0] cnt);
        check({tag, ".valid"}, 64'(bus_a.wb_valid), 64'(v));
        check({tag, ".we"}, 64'(bus_a.wb_we), 64'(we));
        check({tag, ".data"}, 64'(bus_a.wb_data), 64'(d));
        check({tag, ".rd"}, 64'(bus_a.wb_rd), 64'(rd));
        check({tag, ".instret"}, bus_a.instret, cnt);
    endtask

    initial begin
        logic [31:0] ld_word;
        ld_word = 32'h80FF_7F81;
        rst = 1'b1;
        bus_a.stall = 1'b0; bus_a.flush = 1'b0;
        bus_a.pc_plus4 = '0; bus_a.imm = '0;
        drive_a(1'b0, 2'b00, '0, '0, 3'b000, 2'b00, '0, 1'b0);
        bus_b.in_valid = 1'b0; bus_b.stall = 1'b0; bus_b.flush = 1'b0;
        bus_b.wb_sel = 2'b00; bus_b.alu_res = '0; bus_b.load_data = '0;
        bus_b.pc_plus4 = '0; bus_b.imm = '0; bus_b.funct3 = '0; bus_b.byte_off = '0;
        bus_b.rd_addr = '0; bus_b.rd_we_in = 1'b0;
        step(); step();
        check_a("reset", 1'b0, 1'b0, 32'h0, 5'd0, 64'd0);
        check("reset.b_instret", 64'(bus_b.instret), 64'd0);
        rst = 1'b0;

        // Non-MEM sources
        drive_a(1'b1, 2'b00, 32'h0000_1234, ld_word, 3'b000, 2'b00, 5'd5, 1'b1);
        bus_a.pc_plus4 = 32'h0000_0104; bus_a.imm = 32'hABCD_E000;
        step(); check_a("alu", 1'b1, 1'b1, 32'h0000_1234, 5'd5, 64'd1);
        drive_a(1'b1, 2'b10, 32'h0000_1234, ld_word, 3'b000, 2'b00, 5'd1, 1'b1);
        step(); check_a("pc4", 1'b1, 1'b1, 32'h0000_0104, 5'd1, 64'd2);
        drive_a(1'b1, 2'b11, 32'h0000_1234, ld_word, 3'b000, 2'b00, 5'd31, 1'b1);
        step(); check_a("imm", 1'b1, 1'b1, 32'hABCD_E000, 5'd31, 64'd3);

        // Loads
`ifdef WB_LOAD_EXT_EN
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b000, 2'd0, 5'd2, 1'b1);
        step(); check_a("lb_off0", 1'b1, 1'b1, 32'hFFFF_FF81, 5'd2, 64'd4);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b100, 2'd3, 5'd2, 1'b1);
        step(); check_a("lbu_off3", 1'b1, 1'b1, 32'h0000_0080, 5'd2, 64'd5);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b001, 2'd2, 5'd2, 1'b1);
        step(); check_a("lh_off2", 1'b1, 1'b1, 32'hFFFF_80FF, 5'd2, 64'd6);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b101, 2'd1, 5'd2, 1'b1);
        step(); check_a("lhu_off1", 1'b1, 1'b1, 32'h0000_7F81, 5'd2, 64'd7);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b010, 2'd0, 5'd2, 1'b1);
        step(); check_a("lw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd8);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b111, 2'd2, 5'd2, 1'b1);
        step(); check_a("f3_111", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd9);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b000, 2'd1, 5'd2, 1'b1);
        step(); check_a("lb_off1", 1'b1, 1'b1, 32'h0000_007F, 5'd2, 64'd10);
`else
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b000, 2'd0, 5'd2, 1'b1);
        step(); check_a("lb_raw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd4);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b100, 2'd3, 5'd2, 1'b1);
        step(); check_a("lbu_raw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd5);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b001, 2'd2, 5'd2, 1'b1);
        step(); check_a("lh_raw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd6);
        drive_a(1'b1, 2'b01, '0, 32'h1234_5678, 3'b101, 2'd1, 5'd2, 1'b1);
        step(); check_a("lhu_raw", 1'b1, 1'b1, 32'h1234_5678, 5'd2, 64'd7);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b010, 2'd0, 5'd2, 1'b1);
        step(); check_a("lw_raw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd8);
        drive_a(1'b1, 2'b01, '0, 32'h0000_00F0, 3'b111, 2'd2, 5'd2, 1'b1);
        step(); check_a("f3_111_raw", 1'b1, 1'b1, 32'h0000_00F0, 5'd2, 64'd9);
        drive_a(1'b1, 2'b01, '0, ld_word, 3'b000, 2'd1, 5'd2, 1'b1);
        step(); check_a("lb1_raw", 1'b1, 1'b1, 32'h80FF_7F81, 5'd2, 64'd10);
`endif

        // x0 protection, no-write, bubble
        drive_a(1'b1, 2'b00, 32'h0000_0055, ld_word, 3'b000, 2'd0, 5'd0, 1'b1);
        step(); check_a("x0", 1'b1, 1'b0, 32'h0000_0055, 5'd0, 64'd11);
        drive_a(1'b1, 2'b00, 32'h0000_0066, ld_word, 3'b000, 2'd0, 5'd7, 1'b0);
        step(); check_a("nowe", 1'b1, 1'b0, 32'h0000_0066, 5'd7, 64'd12);
        drive_a(1'b0, 2'b00, 32'h0000_0099, ld_word, 3'b000, 2'd0, 5'd9, 1'b1);
        step(); check_a("bubble", 1'b0, 1'b0, 32'h0000_0000, 5'd9, 64'd12);

        // Stall holds entry A for three cycles
        drive_a(1'b1, 2'b00, 32'h0000_AAAA, ld_word, 3'b000, 2'd0, 5'd10, 1'b1);
        step(); check_a("entry_a", 1'b1, 1'b1, 32'h0000_AAAA, 5'd10, 64'd13);
        drive_a(1'b1, 2'b00, 32'h0000_BBBB, ld_word, 3'b000, 2'd0, 5'd11, 1'b1);
        bus_a.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); check_a($sformatf("stall%0d", k), 1'b1, 1'b1, 32'h0000_AAAA, 5'd10, 64'd13);
        end
        bus_a.stall = 1'b0;
        step(); check_a("release", 1'b1, 1'b1, 32'h0000_BBBB, 5'd11, 64'd14);

        // Flush beats stall; flush alone also bubbles
        drive_a(1'b1, 2'b00, 32'h0000_CCCC, ld_word, 3'b000, 2'd0, 5'd12, 1'b1);
        bus_a.stall = 1'b1; bus_a.flush = 1'b1;
        step(); check_a("stall_flush", 1'b0, 1'b0, 32'h0, 5'd0, 64'd14);
        bus_a.stall = 1'b0;
        bus_a.alu_res = 32'h0000_DDDD;
        step(); check_a("flush", 1'b0, 1'b0, 32'h0, 5'd0, 64'd14);
        bus_a.flush = 1'b0;
        step(); check_a("post_flush", 1'b1, 1'b1, 32'h0000_DDDD, 5'd12, 64'd15);

        // 4-bit counter wrap on the second instance
        bus_b.in_valid = 1'b1; bus_b.rd_we_in = 1'b1; bus_b.rd_addr = 5'd3;
        for (int i = 0; i < 16; i++) begin
            bus_b.alu_res = 32'(i) + 32'h100;
            step();
            check($sformatf("wrap%0d", i), 64'(bus_b.instret), 64'((i + 1) % 16));
        end
        check("wrap.data", 64'(bus_b.wb_data), 64'h10F);

        // Reset mid-stream
        drive_a(1'b1, 2'b00, 32'h0000_EEEE, ld_word, 3'b000, 2'd0, 5'd13, 1'b1);
        rst = 1'b1;
        step();
        check_a("mid_rst", 1'b0, 1'b0, 32'h0, 5'd0, 64'd0);
        check("mid_rst.b_instret", 64'(bus_b.instret), 64'd0);
        check("mid_rst.b_valid", 64'(bus_b.wb_valid), 64'd0);
        rst = 1'b0;
        step(); check_a("after_rst", 1'b1, 1'b1, 32'h0000_EEEE, 5'd13, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
